// File: rtl/fpu_req_ctrl.sv
// Core-side FPU request controller: accepts one decoded FP instruction, issues it,
// collects the tagged result into writeback, and owns the frm/fflags CSR state.
module fpu_req_ctrl #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // decode side
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [3:0]             dec_op_i,
  input  logic                   dec_op_mod_i,
  input  logic [2:0]             dec_rm_i,
  input  logic [3*WIDTH-1:0]     dec_operands_i,
  input  logic [4:0]             dec_rd_i,
  input  logic                   dec_int_dst_i,
  // FPU request/response
  output logic                   fpu_in_valid_o,
  input  logic                   fpu_in_ready_i,
  output logic [3:0]             fpu_op_o,
  output logic                   fpu_op_mod_o,
  output logic [2:0]             fpu_rnd_mode_o,
  output logic [3*WIDTH-1:0]     fpu_operands_o,
  output logic [TAG_WIDTH-1:0]   fpu_tag_o,
  input  logic                   fpu_out_valid_i,
  output logic                   fpu_out_ready_o,
  input  logic [WIDTH-1:0]       fpu_result_i,
  input  logic [4:0]             fpu_status_i,
  input  logic [TAG_WIDTH-1:0]   fpu_tag_i,
  // writeback
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic                   wb_int_o,
  output logic [WIDTH-1:0]       wb_data_o,
  // CSR and status
  input  logic                   csr_we_i,
  input  logic [1:0]             csr_sel_i,
  input  logic [7:0]             csr_wdata_i,
  output logic [2:0]             frm_o,
  output logic [4:0]             fflags_o,
  output logic                   illegal_o,
  output logic                   tag_err_o,
  output logic                   busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  localparam logic [2:0] RM_DYN = 3'b111;
  localparam logic [3:0] OP_I2F = 4'd12;

  logic [1:0]           state_reg, state_next;
  logic [3:0]           op_reg;
  logic                 op_mod_reg;
  logic [2:0]           rm_reg;
  logic [3*WIDTH-1:0]   operands_reg;
  logic [TAG_WIDTH-1:0] tag_reg;
  logic [WIDTH-1:0]     result_reg;
  logic [2:0]           frm_reg, frm_next;
  logic [4:0]           fflags_reg, fflags_next;
  logic                 illegal_reg;
  logic                 tag_err_reg;

  logic [2:0]           rm_resolved;
  logic                 insn_bad;
  logic                 accept;
  logic                 legal_accept;
  logic                 resp;
  logic                 tag_hit;

  // Dynamic rounding picks up frm at acceptance; later frm writes do not reach
  // the in-flight instruction because rm_reg is captured here.
  assign rm_resolved  = (dec_rm_i == RM_DYN) ? frm_reg : dec_rm_i;
  assign insn_bad     = (rm_resolved >= 3'b101) || (dec_op_i > OP_I2F);
  assign accept       = (state_reg == IDLE) && dec_valid_i;
  assign legal_accept = accept && !insn_bad;
  assign resp         = (state_reg == WAIT) && fpu_out_valid_i;
  assign tag_hit      = (fpu_tag_i == tag_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (legal_accept) state_next = ISSUE;
      ISSUE:   if (fpu_in_ready_i) state_next = WAIT;
      WAIT:    if (fpu_out_valid_i) state_next = tag_hit ? WB : IDLE;
      WB:      if (wb_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // CSR write value (or current value) forms the base; accumulated flags OR on top.
  always_comb begin
    frm_next    = frm_reg;
    fflags_next = fflags_reg;
    if (csr_we_i) begin
      case (csr_sel_i)
        2'b01: fflags_next = csr_wdata_i[4:0];
        2'b10: frm_next    = csr_wdata_i[2:0];
        2'b11: begin
          frm_next    = csr_wdata_i[7:5];
          fflags_next = csr_wdata_i[4:0];
        end
        default: ;
      endcase
    end
    if (resp && tag_hit) fflags_next = fflags_next | fpu_status_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      op_mod_reg   <= 1'b0;
      rm_reg       <= '0;
      operands_reg <= '0;
      tag_reg      <= '0;
      result_reg   <= '0;
      frm_reg      <= '0;
      fflags_reg   <= '0;
      illegal_reg  <= 1'b0;
      tag_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      frm_reg     <= frm_next;
      fflags_reg  <= fflags_next;
      illegal_reg <= accept && insn_bad;
      tag_err_reg <= resp && !tag_hit;
      if (legal_accept) begin
        op_reg       <= dec_op_i;
        op_mod_reg   <= dec_op_mod_i;
        rm_reg       <= rm_resolved;
        operands_reg <= dec_operands_i;
        tag_reg      <= TAG_WIDTH'({dec_int_dst_i, dec_rd_i});
      end
      if (resp && tag_hit) result_reg <= fpu_result_i;
    end
  end

  // Every output comes straight from registered state.
  assign dec_ready_o     = (state_reg == IDLE);
  assign fpu_in_valid_o  = (state_reg == ISSUE);
  assign fpu_out_ready_o = (state_reg == WAIT);
  assign wb_valid_o      = (state_reg == WB);
  assign busy_o          = (state_reg != IDLE);
  assign fpu_op_o        = op_reg;
  assign fpu_op_mod_o    = op_mod_reg;
  assign fpu_rnd_mode_o  = rm_reg;
  assign fpu_operands_o  = operands_reg;
  assign fpu_tag_o       = tag_reg;
  assign wb_rd_o         = tag_reg[4:0];
  assign wb_int_o        = tag_reg[5];
  assign wb_data_o       = result_reg;
  assign frm_o           = frm_reg;
  assign fflags_o        = fflags_reg;
  assign illegal_o       = illegal_reg;
  assign tag_err_o       = tag_err_reg;

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// Directed bench for fpu_req_ctrl: issue/writeback flow, flags, illegal decode,
// backpressure, tag mismatch, reset mid-flight and CSR/flag collision.
module tb_fpu_req_ctrl;
  localparam int WIDTH = 32;
  localparam int TAG_WIDTH = 6;
  localparam logic [3:0] OP_ADD = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4, OP_I2F = 4'd12, OP_CPKAB = 4'd13;

  logic clk, rst_n;
  logic dec_valid, dec_ready, dec_op_mod, dec_int_dst;
  logic [3:0] dec_op;
  logic [2:0] dec_rm;
  logic [3*WIDTH-1:0] dec_operands;
  logic [4:0] dec_rd;
  logic fpu_in_valid, fpu_in_ready, fpu_op_mod, fpu_out_valid, fpu_out_ready;
  logic [3:0] fpu_op;
  logic [2:0] fpu_rnd_mode;
  logic [3*WIDTH-1:0] fpu_operands;
  logic [TAG_WIDTH-1:0] fpu_tag, fpu_tag_in;
  logic [WIDTH-1:0] fpu_result;
  logic [4:0] fpu_status;
  logic wb_valid, wb_ready, wb_int;
  logic [4:0] wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic csr_we;
  logic [1:0] csr_sel;
  logic [7:0] csr_wdata;
  logic [2:0] frm;
  logic [4:0] fflags;
  logic illegal, tag_err, busy;

  int errors = 0;
  int checks = 0;

  fpu_req_ctrl #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_op_i(dec_op),
    .dec_op_mod_i(dec_op_mod), .dec_rm_i(dec_rm), .dec_operands_i(dec_operands),
    .dec_rd_i(dec_rd), .dec_int_dst_i(dec_int_dst),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready), .fpu_op_o(fpu_op),
    .fpu_op_mod_o(fpu_op_mod), .fpu_rnd_mode_o(fpu_rnd_mode), .fpu_operands_o(fpu_operands),
    .fpu_tag_o(fpu_tag), .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd), .wb_int_o(wb_int),
    .wb_data_o(wb_data),
    .csr_we_i(csr_we), .csr_sel_i(csr_sel), .csr_wdata_i(csr_wdata),
    .frm_o(frm), .fflags_o(fflags), .illegal_o(illegal), .tag_err_o(tag_err), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dec(input logic [3:0] op, input logic [2:0] rm, input logic [4:0] rd,
                           input logic int_dst, input logic [3*WIDTH-1:0] ops);
    dec_valid = 1'b1; dec_op = op; dec_op_mod = 1'b0; dec_rm = rm;
    dec_rd = rd; dec_int_dst = int_dst; dec_operands = ops;
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [7:0] wdata);
    csr_we = 1'b1; csr_sel = sel; csr_wdata = wdata;
    tick();
    csr_we = 1'b0; csr_sel = 2'b00; csr_wdata = 8'h00;
  endtask

  // Zero-wait instruction: accept, issue, response, writeback.
  task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic [WIDTH-1:0] res,
                        input logic [4:0] st);
    drive_dec(op, 3'b000, rd, 1'b0, {3*WIDTH{1'b0}});
    fpu_in_ready = 1'b1; wb_ready = 1'b1;
    tick();
    dec_valid = 1'b0;
    tick();
    fpu_out_valid = 1'b1; fpu_result = res; fpu_status = st; fpu_tag_in = {1'b0, rd};
    tick();
    fpu_out_valid = 1'b0; fpu_status = 5'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready got=%0b exp=1", dec_ready); end
    checks++; if ({fpu_in_valid, fpu_out_ready, wb_valid, busy, illegal, tag_err} !== 6'b0) begin errors++; $display("FAIL reset_handshakes got=%06b exp=000000", {fpu_in_valid, fpu_out_ready, wb_valid, busy, illegal, tag_err}); end
    checks++; if ({frm, fflags, fpu_tag, wb_data} !== '0) begin errors++; $display("FAIL reset_regs frm=%0h fflags=%0h tag=%0h wb_data=%0h exp all 0", frm, fflags, fpu_tag, wb_data); end
    rst_n = 1'b1;
    tick();
    $display("reset: dec_ready=%0b busy=%0b frm=%0h fflags=%0h", dec_ready, busy, frm, fflags);
  endtask

  task automatic test_add();
    fpu_in_ready = 1'b1; wb_ready = 1'b1;
    drive_dec(OP_ADD, 3'b111, 5'd3, 1'b0, {32'h0, 32'h40000000, 32'h3F800000});
    tick();
    dec_valid = 1'b0;
    checks++; if (fpu_in_valid !== 1'b1) begin errors++; $display("FAIL add_in_valid got=%0b exp=1", fpu_in_valid); end
    checks++; if (fpu_rnd_mode !== 3'b000) begin errors++; $display("FAIL add_rm got=%0b exp=000", fpu_rnd_mode); end
    checks++; if (fpu_tag !== 6'h03) begin errors++; $display("FAIL add_tag got=%0h exp=03", fpu_tag); end
    checks++; if (fpu_operands !== {32'h0, 32'h40000000, 32'h3F800000} || fpu_op !== OP_ADD) begin errors++; $display("FAIL add_payload op=%0d ops=%0h", fpu_op, fpu_operands); end
    tick();
    checks++; if (fpu_out_ready !== 1'b1) begin errors++; $display("FAIL add_out_ready got=%0b exp=1", fpu_out_ready); end
    fpu_out_valid = 1'b1; fpu_result = 32'h40400000; fpu_status = 5'b0; fpu_tag_in = 6'h03;
    tick();
    fpu_out_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_int !== 1'b0 || wb_data !== 32'h40400000) begin errors++; $display("FAIL add_wb valid=%0b rd=%0d int=%0b data=%0h exp 1/3/0/40400000", wb_valid, wb_rd, wb_int, wb_data); end
    tick();
    checks++; if (dec_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL add_loop4 dec_ready=%0b busy=%0b exp 1/0", dec_ready, busy); end
    $display("add: wb_data=40400000 rd=3 done in 4 cycles, fflags=%05b", fflags);
  endtask

  task automatic test_flag_accumulation();
    run_op(OP_DIV, 5'd5, 32'h3F000000, 5'b01000);
    checks++; if (fflags !== 5'b01000) begin errors++; $display("FAIL flags_first got=%05b exp=01000", fflags); end
    run_op(OP_DIV, 5'd6, 32'h3E800000, 5'b00001);
    checks++; if (fflags !== 5'b01001) begin errors++; $display("FAIL flags_accum got=%05b exp=01001", fflags); end
    csr_write(2'b01, 8'h00);
    checks++; if (fflags !== 5'b00000 || frm !== 3'b000) begin errors++; $display("FAIL flags_clear fflags=%05b frm=%03b exp 00000/000", fflags, frm); end
    $display("flags: accumulated 01001 then cleared by csr");
  endtask

  task automatic test_illegal();
    csr_write(2'b10, 8'h05);
    checks++; if (frm !== 3'b101) begin errors++; $display("FAIL ill_frm_write got=%03b exp=101", frm); end
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive_dec(OP_ADD, 3'b111, 5'd1, 1'b0, '0);
      else if (k == 1) drive_dec(OP_ADD, 3'b110, 5'd1, 1'b0, '0);
      else drive_dec(OP_CPKAB, 3'b000, 5'd1, 1'b0, '0);
      tick();
      dec_valid = 1'b0;
      checks++; if (illegal !== 1'b1 || fpu_in_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ill_case%0d illegal=%0b in_valid=%0b busy=%0b exp 1/0/0", k, illegal, fpu_in_valid, busy); end
      tick();
      checks++; if (illegal !== 1'b0 || fpu_in_valid !== 1'b0) begin errors++; $display("FAIL ill_pulse%0d illegal=%0b in_valid=%0b exp 0/0", k, illegal, fpu_in_valid); end
      $display("illegal case %0d rejected", k);
    end
    csr_write(2'b10, 8'h00);
    // I2F with RMM is the last legal op/rm combination.
    fpu_in_ready = 1'b1; wb_ready = 1'b1;
    drive_dec(OP_I2F, 3'b100, 5'd9, 1'b0, {3{32'h00000007}});
    tick();
    dec_valid = 1'b0;
    checks++; if (fpu_in_valid !== 1'b1 || fpu_rnd_mode !== 3'b100 || illegal !== 1'b0 || fpu_op !== OP_I2F) begin errors++; $display("FAIL ill_i2f_legal in_valid=%0b rm=%03b illegal=%0b op=%0d", fpu_in_valid, fpu_rnd_mode, illegal, fpu_op); end
    tick();
    fpu_out_valid = 1'b1; fpu_result = 32'h40E00000; fpu_status = 5'b0; fpu_tag_in = 6'h09;
    tick();
    fpu_out_valid = 1'b0;
    tick();
    $display("illegal: I2F/RMM accepted");
  endtask

  task automatic test_backpressure();
    logic [3*WIDTH-1:0] ops;
    ops = {32'h11111111, 32'h22222222, 32'h33333333};
    fpu_in_ready = 1'b0; wb_ready = 1'b0;
    drive_dec(OP_MUL, 3'b001, 5'd10, 1'b1, ops);
    tick();
    // Keep offering a different instruction and retune frm while busy.
    drive_dec(OP_ADD, 3'b111, 5'd2, 1'b0, '1);
    csr_write(2'b10, 8'h03);
    for (int k = 0; k < 5; k++) begin
      checks++; if ({fpu_in_valid, dec_ready, fpu_op, fpu_rnd_mode, fpu_tag, fpu_operands} !== {1'b1, 1'b0, OP_MUL, 3'b001, 6'h2A, ops}) begin errors++; $display("FAIL bp_issue%0d in_valid=%0b dec_ready=%0b op=%0d rm=%03b tag=%0h", k, fpu_in_valid, dec_ready, fpu_op, fpu_rnd_mode, fpu_tag); end
      if (k < 4) tick();
    end
    fpu_in_ready = 1'b1;
    tick();
    fpu_out_valid = 1'b1; fpu_result = 32'hC0A00000; fpu_status = 5'b0; fpu_tag_in = 6'h2A;
    tick();
    fpu_out_valid = 1'b0; fpu_result = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({wb_valid, dec_ready, wb_rd, wb_int, wb_data} !== {1'b1, 1'b0, 5'd10, 1'b1, 32'hC0A00000}) begin errors++; $display("FAIL bp_wb%0d valid=%0b dec_ready=%0b rd=%0d int=%0b data=%0h", k, wb_valid, dec_ready, wb_rd, wb_int, wb_data); end
      if (k < 2) tick();
    end
    dec_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    checks++; if (dec_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_done dec_ready=%0b busy=%0b exp 1/0", dec_ready, busy); end
    csr_write(2'b10, 8'h00);
    $display("backpressure: payloads held 5 issue and 3 wb cycles");
  endtask

  task automatic test_tag_mismatch();
    fpu_in_ready = 1'b1; wb_ready = 1'b1;
    drive_dec(OP_ADD, 3'b000, 5'd3, 1'b1, '0);
    tick();
    dec_valid = 1'b0;
    checks++; if (fpu_tag !== 6'h23) begin errors++; $display("FAIL tm_req_tag got=%0h exp=23", fpu_tag); end
    tick();
    fpu_out_valid = 1'b1; fpu_result = 32'h12345678; fpu_status = 5'b10000; fpu_tag_in = 6'h05;
    tick();
    fpu_out_valid = 1'b0; fpu_status = 5'b0;
    checks++; if (tag_err !== 1'b1 || fflags !== 5'b0 || wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tm_resp tag_err=%0b fflags=%05b wb_valid=%0b busy=%0b exp 1/00000/0/0", tag_err, fflags, wb_valid, busy); end
    tick();
    checks++; if (tag_err !== 1'b0 || wb_valid !== 1'b0 || dec_ready !== 1'b1) begin errors++; $display("FAIL tm_after tag_err=%0b wb_valid=%0b dec_ready=%0b exp 0/0/1", tag_err, wb_valid, dec_ready); end
    $display("tag mismatch: response 05 vs request 23 dropped");
  endtask

  task automatic test_reset_collision();
    csr_write(2'b11, 8'h55);
    checks++; if (frm !== 3'b010 || fflags !== 5'b10101) begin errors++; $display("FAIL rc_pre frm=%03b fflags=%05b exp 010/10101", frm, fflags); end
    fpu_in_ready = 1'b1; wb_ready = 1'b1;
    drive_dec(OP_ADD, 3'b000, 5'd1, 1'b0, '1);
    tick();
    dec_valid = 1'b0;
    tick();
    checks++; if (fpu_out_ready !== 1'b1) begin errors++; $display("FAIL rc_in_wait out_ready=%0b exp=1", fpu_out_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if ({dec_ready, fpu_in_valid, fpu_out_ready, wb_valid, busy, illegal, tag_err} !== 7'b1000000) begin errors++; $display("FAIL rc_reset_hs got=%07b exp=1000000", {dec_ready, fpu_in_valid, fpu_out_ready, wb_valid, busy, illegal, tag_err}); end
    checks++; if ({frm, fflags, fpu_tag, fpu_operands} !== '0) begin errors++; $display("FAIL rc_reset_regs frm=%03b fflags=%05b tag=%0h", frm, fflags, fpu_tag); end
    #1;
    rst_n = 1'b1;
    tick();
    drive_dec(OP_ADD, 3'b000, 5'd7, 1'b0, '0);
    tick();
    dec_valid = 1'b0;
    tick();
    fpu_out_valid = 1'b1; fpu_result = 32'h00001234; fpu_status = 5'b00100; fpu_tag_in = 6'h07;
    csr_we = 1'b1; csr_sel = 2'b11; csr_wdata = 8'h41;
    tick();
    fpu_out_valid = 1'b0; fpu_status = 5'b0; csr_we = 1'b0; csr_sel = 2'b00;
    checks++; if (frm !== 3'b010 || fflags !== 5'b00101) begin errors++; $display("FAIL rc_collision frm=%03b fflags=%05b exp 010/00101", frm, fflags); end
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h00001234 || wb_rd !== 5'd7) begin errors++; $display("FAIL rc_wb valid=%0b data=%0h rd=%0d exp 1/1234/7", wb_valid, wb_data, wb_rd); end
    tick();
    $display("reset+collision: frm=%03b fflags=%05b", frm, fflags);
  endtask

  initial begin
    rst_n = 1'b1;
    dec_valid = 0; dec_op = 0; dec_op_mod = 0; dec_rm = 0; dec_operands = '0; dec_rd = 0; dec_int_dst = 0;
    fpu_in_ready = 0; fpu_out_valid = 0; fpu_result = '0; fpu_status = '0; fpu_tag_in = '0;
    wb_ready = 0; csr_we = 0; csr_sel = 0; csr_wdata = 0;
    #2;
    test_reset();
    test_add();
    test_flag_accumulation();
    test_illegal();
    test_backpressure();
    test_tag_mismatch();
    test_reset_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
